board_scanner: RTL and testbench
================================

Name: board_scanner

Overview:
- Read-side companion to the game-logic board writer.
- On request, walks the current SIZE x SIZE board through a synchronous read port and reports three results:
  - whether the board is solved (every cell equals cell (0,0));
  - how many cells match the flood colour;
  - whether any cell holds an out-of-range colour.
- Sits between the game logic (board owner) and the selector/digit display, which use WIN to end a game and MATCH_COUNT for progress.

Parameters:
- MAX_SIZE, 26, largest board edge supported; SIZE is clamped to this.
- COLOR_W, 3, bits per cell colour.
- CNT_W, 10, width of MATCH_COUNT; must hold MAX_SIZE*MAX_SIZE (676).

Ports:
- CLOCK  in  1  system clock (game-logic clock domain).
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle scan request.
- SIZE  in  5  board edge; sampled on accepted START.
- COLOR_NUM  in  4  number of legal colours; sampled on accepted START.
- RD_ROW  out  5  board read row address.
- RD_COL  out  5  board read column address.
- RD_COLOR  in  COLOR_W  cell colour; valid 1 cycle after address.
- BUSY  out  1  high while a scan is in progress.
- DONE  out  1  one-cycle pulse when results are valid.
- WIN  out  1  all scanned cells equal cell (0,0).
- MATCH_COUNT  out  CNT_W  count of cells equal to cell (0,0).
- BAD_COLOR  out  1  some cell value >= sampled COLOR_NUM.
- COLOR_PRESENT  out  8  bit k set if colour k appears (optional; see below).

Behaviour:
- Reset: asynchronous on RESET_N low. All outputs are 0 and the FSM is in IDLE. A reset mid-scan aborts the scan with no DONE.
- States: IDLE -> SCAN -> DRAIN -> FIN -> IDLE.
- IDLE
  - START=1 latches n = min(SIZE, MAX_SIZE) and COLOR_NUM, then clears the accumulators.
  - If n==0: go to FIN directly with WIN=1, MATCH_COUNT=0, BAD_COLOR=0.
  - Otherwise go to SCAN with RD_ROW=RD_COL=0.
  - BUSY rises the cycle after START.
- SCAN
  - Issues one address per cycle in row-major order; column wraps at n-1 and row increments.
  - After issuing (n-1, n-1), go to DRAIN.
  - The address is held at (n-1, n-1) while in DRAIN.
- Data pipeline
  - A one-cycle delayed valid tags each returning RD_COLOR.
  - The first returned sample (cell 0,0) becomes REF and counts as a match.
  - Each later sample equal to REF increments MATCH_COUNT; any mismatch clears the internal all-equal flag.
  - Any sample >= latched COLOR_NUM sets BAD_COLOR.
- DRAIN: consumes the final sample, then goes to FIN.
- FIN
  - DONE=1 for exactly one cycle; BUSY falls in the same cycle.
  - WIN = all-equal AND NOT BAD_COLOR.
- Latency: START at cycle t gives DONE at cycle t + n*n + 3.
- Hold: WIN, MATCH_COUNT and BAD_COLOR hold their values after DONE until the next accepted START. On that START they clear to 0 in the same edge.
- START while BUSY is ignored (no restart, no queueing).
- START coincident with FIN is also ignored; START is accepted only in IDLE.
- MATCH_COUNT does not wrap: the maximum is 676 < 2^CNT_W.
- Input stability: SIZE and COLOR_NUM changes during a scan have no effect.

Optional Feature:
- Macro: BOARD_SCANNER_PRESENT_EN.
- Defined: COLOR_PRESENT[k] is set when any valid sample equals k. It is cleared on accepted START, valid from DONE, and held like the other results.
- Not defined: COLOR_PRESENT is tied to 0 and no presence logic is built.
- All other behaviour is identical in both builds.

Test Plan:
- Uniform board: SIZE=14, all cells colour 2, COLOR_NUM=6, START -> DONE exactly 199 cycles after START; WIN=1, MATCH_COUNT=196, BAD_COLOR=0; COLOR_PRESENT=8'h04 when the macro is defined.
- Single mismatch: SIZE=2 board {1,1,1,3}, COLOR_NUM=4 -> WIN=0, MATCH_COUNT=3; COLOR_PRESENT=8'h0A when the macro is defined.
- Clamp and zero:
  - SIZE=30 on a uniform board -> scans 26x26; MATCH_COUNT=676, DONE at +679.
  - SIZE=0 -> DONE at +2, WIN=1, MATCH_COUNT=0.
- Bad colour: SIZE=6 uniform colour 5 with COLOR_NUM=4 -> BAD_COLOR=1, WIN=0, MATCH_COUNT=36.
- Reset and restart:
  - Pulse RESET_N low 10 cycles into a SIZE=10 scan -> all outputs 0 immediately; no DONE follows.
  - A new START then completes normally at +103.
- START while BUSY: START pulses again during a SIZE=5 scan -> single DONE at +28 from the first START; results unchanged.

Source files
------------

// File: rtl/board_scanner.sv
// Walks a SIZE x SIZE board through a synchronous read port and reports WIN / MATCH_COUNT / BAD_COLOR.
// Define BOARD_SCANNER_PRESENT_EN to build the COLOR_PRESENT colour-presence vector.
module board_scanner #(
    parameter int MAX_SIZE = 26,
    parameter int COLOR_W  = 3,
    parameter int CNT_W    = 10
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               START,
    input  logic [4:0]         SIZE,
    input  logic [3:0]         COLOR_NUM,
    output logic [4:0]         RD_ROW,
    output logic [4:0]         RD_COL,
    input  logic [COLOR_W-1:0] RD_COLOR,
    output logic               BUSY,
    output logic               DONE,
    output logic               WIN,
    output logic [CNT_W-1:0]   MATCH_COUNT,
    output logic               BAD_COLOR,
    output logic [7:0]         COLOR_PRESENT
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_e;

    state_e             state_q, state_d;
    logic [4:0]         n_q, n_d;
    logic [3:0]         cnum_q, cnum_d;
    logic [4:0]         row_q, row_d;
    logic [4:0]         col_q, col_d;
    logic               valid_q, valid_d;
    logic               first_q, first_d;
    logic [COLOR_W-1:0] ref_q, ref_d;
    logic               all_eq_q, all_eq_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bad_q, bad_d;
    logic               win_q, win_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [4:0]         n_clamp;
`ifdef BOARD_SCANNER_PRESENT_EN
    logic [7:0]         present_q, present_d;
`endif

    assign n_clamp = (SIZE > 5'(MAX_SIZE)) ? 5'(MAX_SIZE) : SIZE;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        n_d      = n_q;
        cnum_d   = cnum_q;
        row_d    = row_q;
        col_d    = col_q;
        valid_d  = 1'b0;
        first_d  = first_q;
        ref_d    = ref_q;
        all_eq_d = all_eq_q;
        cnt_d    = cnt_q;
        bad_d    = bad_q;
        win_d    = win_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef BOARD_SCANNER_PRESENT_EN
        present_d = present_q;
`endif

        // Returning sample for the address issued on the previous cycle.
        if (valid_q) begin
            if (first_q) begin
                ref_d   = RD_COLOR;
                first_d = 1'b0;
                cnt_d   = CNT_W'(1);
            end else if (RD_COLOR == ref_q) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                all_eq_d = 1'b0;
            end
            if (32'(RD_COLOR) >= 32'(cnum_q)) bad_d = 1'b1;
`ifdef BOARD_SCANNER_PRESENT_EN
            for (int k = 0; k < 8; k++) begin
                if (32'(RD_COLOR) == k) present_d[k] = 1'b1;
            end
`endif
        end

        case (state_q)
            IDLE: begin
                if (START) begin
                    n_d      = n_clamp;
                    cnum_d   = COLOR_NUM;
                    row_d    = 5'd0;
                    col_d    = 5'd0;
                    first_d  = 1'b1;
                    all_eq_d = 1'b1;
                    cnt_d    = '0;
                    bad_d    = 1'b0;
                    win_d    = 1'b0;
                    busy_d   = 1'b1;
`ifdef BOARD_SCANNER_PRESENT_EN
                    present_d = 8'h00;
`endif
                    state_d  = (n_clamp == 5'd0) ? FIN : SCAN;
                end
            end
            SCAN: begin
                valid_d = 1'b1;
                if (row_q == n_q - 5'd1 && col_q == n_q - 5'd1) begin
                    state_d = DRAIN;
                end else if (col_q == n_q - 5'd1) begin
                    col_d = 5'd0;
                    row_d = row_q + 5'd1;
                end else begin
                    col_d = col_q + 5'd1;
                end
            end
            DRAIN: state_d = FIN;
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                win_d   = all_eq_q & ~bad_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            n_q      <= '0;
            cnum_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            ref_q    <= '0;
            all_eq_q <= 1'b0;
            cnt_q    <= '0;
            bad_q    <= 1'b0;
            win_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BOARD_SCANNER_PRESENT_EN
            present_q <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cnum_q   <= cnum_d;
            row_q    <= row_d;
            col_q    <= col_d;
            valid_q  <= valid_d;
            first_q  <= first_d;
            ref_q    <= ref_d;
            all_eq_q <= all_eq_d;
            cnt_q    <= cnt_d;
            bad_q    <= bad_d;
            win_q    <= win_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef BOARD_SCANNER_PRESENT_EN
            present_q <= present_d;
`endif
        end
    end

    assign RD_ROW      = row_q;
    assign RD_COL      = col_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign WIN         = win_q;
    assign MATCH_COUNT = cnt_q;
    assign BAD_COLOR   = bad_q;
`ifdef BOARD_SCANNER_PRESENT_EN
    assign COLOR_PRESENT = present_q;
`else
    assign COLOR_PRESENT = 8'h00;
`endif

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench for board_scanner: a 26x26 board model with a one-cycle synchronous read port.
// Expected COLOR_PRESENT values apply when BOARD_SCANNER_PRESENT_EN is defined, else 0.
module tb_board_scanner;

    logic       CLOCK = 1'b0;
    logic       RESET_N;
    logic       START;
    logic [4:0] SIZE;
    logic [3:0] COLOR_NUM;
    logic [4:0] RD_ROW;
    logic [4:0] RD_COL;
    logic [2:0] RD_COLOR;
    logic       BUSY;
    logic       DONE;
    logic       WIN;
    logic [9:0] MATCH_COUNT;
    logic       BAD_COLOR;
    logic [7:0] COLOR_PRESENT;

    logic [2:0] board [0:25][0:25];
    int n_cmp = 0;
    int n_bad = 0;

    board_scanner dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .SIZE(SIZE),
        .COLOR_NUM(COLOR_NUM), .RD_ROW(RD_ROW), .RD_COL(RD_COL),
        .RD_COLOR(RD_COLOR), .BUSY(BUSY), .DONE(DONE), .WIN(WIN),
        .MATCH_COUNT(MATCH_COUNT), .BAD_COLOR(BAD_COLOR),
        .COLOR_PRESENT(COLOR_PRESENT)
    );

    always #5 CLOCK = ~CLOCK;

    // Synchronous read: data for the address seen at an edge appears after that edge.
    always @(posedge CLOCK)
        RD_COLOR <= (RD_ROW < 5'd26 && RD_COL < 5'd26) ? board[RD_ROW][RD_COL] : 3'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [2:0] c);
        for (int r = 0; r < 26; r++)
            for (int k = 0; k < 26; k++)
                board[r][k] = c;
    endtask

    task automatic check_present(input string tag, input logic [7:0] exp);
`ifdef BOARD_SCANNER_PRESENT_EN
        check(tag, COLOR_PRESENT, exp);
`else
        check(tag, COLOR_PRESENT, 8'h00);
`endif
    endtask

    // START high for one cycle; SIZE/COLOR_NUM are scrambled afterwards to prove they were latched.
    task automatic pulse_start(input logic [4:0] size, input logic [3:0] cnum);
        @(negedge CLOCK);
        START = 1'b1; SIZE = size; COLOR_NUM = cnum;
        @(negedge CLOCK);
        START = 1'b0; SIZE = 5'd31; COLOR_NUM = 4'd0;
    endtask

    task automatic run_scan(input string tag, input logic [4:0] size, input logic [3:0] cnum,
                            input int lat, input logic win, input int cnt,
                            input logic bad, input logic [7:0] pres);
        int cycles;
        pulse_start(size, cnum);
        cycles = 1;
        check({tag, ".busy_rise"}, BUSY, 1'b1);
        check({tag, ".win_cleared"}, WIN, 1'b0);
        while (DONE !== 1'b1 && cycles < 800) begin
            @(negedge CLOCK);
            cycles++;
        end
        check({tag, ".latency"}, cycles, lat);
        check({tag, ".busy_fall"}, BUSY, 1'b0);
        check({tag, ".win"}, WIN, win);
        check({tag, ".match"}, MATCH_COUNT, cnt);
        check({tag, ".bad"}, BAD_COLOR, bad);
        check_present({tag, ".present"}, pres);
        @(negedge CLOCK);
        check({tag, ".done_1cyc"}, DONE, 1'b0);
        check({tag, ".match_hold"}, MATCH_COUNT, cnt);
        check({tag, ".win_hold"}, WIN, win);
    endtask

    initial begin
        int seen;
        int first_done;
        int cycles;
        RESET_N = 1'b0; START = 1'b0; SIZE = 5'd0; COLOR_NUM = 4'd0;
        fill(3'd0);
        repeat (3) @(negedge CLOCK);
        check("rst.busy", BUSY, 1'b0);
        check("rst.done", DONE, 1'b0);
        check("rst.win", WIN, 1'b0);
        check("rst.match", MATCH_COUNT, 0);
        check("rst.bad", BAD_COLOR, 1'b0);
        check("rst.addr", {RD_ROW, RD_COL}, 10'd0);
        check_present("rst.present", 8'h00);
        RESET_N = 1'b1;
        @(negedge CLOCK);

        fill(3'd2);
        run_scan("uniform14", 5'd14, 4'd6, 199, 1'b1, 196, 1'b0, 8'h04);

        fill(3'd0);
        board[0][0] = 3'd1; board[0][1] = 3'd1; board[1][0] = 3'd1; board[1][1] = 3'd3;
        run_scan("mismatch2", 5'd2, 4'd4, 7, 1'b0, 3, 1'b0, 8'h0A);

        fill(3'd3);
        run_scan("clamp30", 5'd30, 4'd8, 679, 1'b1, 676, 1'b0, 8'h08);

        run_scan("zero", 5'd0, 4'd8, 2, 1'b1, 0, 1'b0, 8'h00);

        fill(3'd5);
        run_scan("badcolor", 5'd6, 4'd4, 39, 1'b0, 36, 1'b1, 8'h20);

        // Reset 10 cycles into a scan: everything clears at once and no DONE follows.
        fill(3'd1);
        pulse_start(5'd10, 4'd2);
        repeat (9) @(negedge CLOCK);
        RESET_N = 1'b0;
        #1;
        check("midrst.busy", BUSY, 1'b0);
        check("midrst.match", MATCH_COUNT, 0);
        check("midrst.addr", {RD_ROW, RD_COL}, 10'd0);
        check("midrst.win_bad", {WIN, BAD_COLOR, DONE}, 3'b000);
        check_present("midrst.present", 8'h00);
        repeat (2) @(negedge CLOCK);
        RESET_N = 1'b1;
        seen = 0;
        repeat (120) begin
            @(negedge CLOCK);
            if (DONE === 1'b1) seen++;
        end
        check("midrst.no_done", seen, 0);
        run_scan("restart10", 5'd10, 4'd2, 103, 1'b1, 100, 1'b0, 8'h02);

        // Extra START pulses during the scan and coincident with FIN are ignored.
        fill(3'd4);
        pulse_start(5'd5, 4'd5);
        cycles = 1; seen = 0; first_done = 0;
        while (cycles < 60) begin
            if (DONE === 1'b1) begin
                seen++;
                if (first_done == 0) first_done = cycles;
            end
            START = (cycles == 5 || cycles == 27);
            SIZE  = 5'd2;
            @(negedge CLOCK);
            cycles++;
        end
        START = 1'b0;
        check("busy_start.done_count", seen, 1);
        check("busy_start.latency", first_done, 28);
        check("busy_start.match", MATCH_COUNT, 25);
        check("busy_start.win", WIN, 1'b1);
        check("busy_start.idle", BUSY, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
